// File: rtl/slice_deser_if.sv
`default_nettype none
// ============================================================================
// Module      : slice_deser_if
// Description : Bit-serial input and word-parallel output handshake bundle
//               for slice_deser.
// Revision    : 1.0 - initial release
// ============================================================================
interface slice_deser_if #(
    parameter int WIDTH = 6
);
    logic             in_valid;
    logic             in_ready;
    logic             in_bit;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [0:WIDTH-1] out_data;
    logic             out_err;
    logic             out_perr;

    // Producer of bits and consumer of words
    modport master (
        output in_valid, in_bit, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_err, out_perr
    );

    // The collector itself
    modport slave (
        input  in_valid, in_bit, in_last, out_ready,
        output in_ready, out_valid, out_data, out_err, out_perr
    );
endinterface
`default_nettype wire

// File: rtl/slice_deser.sv
`default_nettype none
// ============================================================================
// Module      : slice_deser
// Description : Serial-to-parallel collector, one bit per handshake, index 0
//               first, single-word buffer. SLICE_DESER_PARITY_EN adds a
//               trailing even-parity bit per full frame.
// Revision    : 1.0 - initial release
// ============================================================================
module slice_deser #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    slice_deser_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
`ifdef SLICE_DESER_PARITY_EN
        S_PAR   = 2'd2,
`endif
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [0:WIDTH-1] r_data, w_data_nxt;
    logic             r_err, w_err_nxt;
    logic             w_in_hs;
`ifdef SLICE_DESER_PARITY_EN
    logic             r_perr, w_perr_nxt;
`endif

    assign w_in_hs = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
`ifdef SLICE_DESER_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_err   <= w_err_nxt;
`ifdef SLICE_DESER_PARITY_EN
            r_perr  <= w_perr_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_data_nxt  = r_data;
        w_err_nxt   = r_err;
`ifdef SLICE_DESER_PARITY_EN
        w_perr_nxt  = r_perr;
`endif
        case (r_state)
            S_IDLE, S_SHIFT: begin
                if (w_in_hs) begin
                    for (int i = 0; i < WIDTH; i++) begin
                        if (r_cnt == CNT_W'(i)) begin
                            w_data_nxt[i] = bus.in_bit;
                        end
                    end
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == c_last) begin
`ifdef SLICE_DESER_PARITY_EN
                        w_state_nxt = S_PAR;
`else
                        w_state_nxt = S_HOLD;
`endif
                    end else if (bus.in_last) begin
                        // Short frame: unfilled positions keep their cleared zeros
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_HOLD;
                    end else begin
                        w_state_nxt = S_SHIFT;
                    end
                end
            end
`ifdef SLICE_DESER_PARITY_EN
            S_PAR: begin
                if (w_in_hs) begin
                    w_perr_nxt  = (^r_data) ^ bus.in_bit;
                    w_state_nxt = S_HOLD;
                end
            end
`endif
            S_HOLD: begin
                if (bus.out_ready) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_data_nxt  = '0;
                    w_err_nxt   = 1'b0;
`ifdef SLICE_DESER_PARITY_EN
                    w_perr_nxt  = 1'b0;
`endif
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (r_state != S_HOLD);
    assign bus.out_valid = (r_state == S_HOLD);
    assign bus.out_data  = r_data;
    assign bus.out_err   = r_err;
`ifdef SLICE_DESER_PARITY_EN
    assign bus.out_perr  = r_perr;
`else
    assign bus.out_perr  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_slice_deser.sv
`default_nettype none
// ============================================================================
// Module      : tb_slice_deser
// Description : Self-checking bench for slice_deser: vector table, directed
//               corner sequences and randomized frames against a frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slice_deser;

`ifdef SLICE_DESER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;

    slice_deser_if #(.WIDTH(6)) bus ();

    slice_deser #(.WIDTH(6), .CNT_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:5] bits;
        int         len;
        logic       lastf;
        logic       p;
        int         gap;
        int         hold;
        logic [0:5] exp_data;
        logic       exp_err;
        logic       exp_perr;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one bit and returns one step after the edge that accepted it
    task automatic send_bit(input logic b, input logic l, input int gap);
        int n;
        repeat (gap) begin
            bus.in_valid = 1'b0;
            tick();
        end
        bus.in_valid = 1'b1;
        bus.in_bit   = b;
        bus.in_last  = l;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [0:5] bits, input int len, input logic lastf,
                              input logic p, input int gap);
        for (int i = 0; i < len; i++) begin
            send_bit(bits[i], (i == len - 1) ? lastf : 1'b0, gap);
        end
        if (PAR_EN && len == 6) send_bit(p, 1'($urandom_range(1, 0)), gap);
    endtask

    task automatic check_word(input string nm, input logic [0:5] ed, input logic ee,
                              input logic ep, input int hold);
        check({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({nm, "_inrdy"}, 32'(bus.in_ready), 32'd0);
        repeat (hold) tick();
        check({nm, "_data"}, 32'(bus.out_data), 32'(ed));
        check({nm, "_err"},  32'(bus.out_err),  32'(ee));
        check({nm, "_perr"}, 32'(bus.out_perr), 32'(ep));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({nm, "_rel_valid"}, 32'(bus.out_valid), 32'd0);
        check({nm, "_rel_inrdy"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:5] bits, expd, c_word;
        int         len, ones, gap, hold;
        logic       lastf, p, eerr, eperr;

        //            bits       len last p  gap hold exp_data   err perr
        tbl[0] = '{6'b101100, 6, 1'b1, 1'b1, 0, 0, 6'b101100, 1'b0, 1'b0};
        tbl[1] = '{6'b110000, 3, 1'b1, 1'b0, 0, 2, 6'b110000, 1'b1, 1'b0};
        tbl[2] = '{6'b111111, 6, 1'b0, 1'b1, 1, 0, 6'b111111, 1'b0, 1'b1};
        tbl[3] = '{6'b100000, 1, 1'b1, 1'b0, 2, 1, 6'b100000, 1'b1, 1'b0};
        tbl[4] = '{6'b010101, 6, 1'b1, 1'b0, 0, 3, 6'b010101, 1'b0, 1'b1};
        tbl[5] = '{6'b101100, 6, 1'b1, 1'b0, 1, 0, 6'b101100, 1'b0, 1'b1};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data",  32'(bus.out_data),  32'd0);
        check("rst_err",   32'(bus.out_err),   32'd0);
        check("rst_perr",  32'(bus.out_perr),  32'd0);
        check("rst_inrdy", 32'(bus.in_ready),  32'd1);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            send_frame(tbl[v].bits, tbl[v].len, tbl[v].lastf, tbl[v].p, tbl[v].gap);
            check_word($sformatf("vec%0d", v), tbl[v].exp_data, tbl[v].exp_err,
                       PAR_EN ? tbl[v].exp_perr : 1'b0, tbl[v].hold);
        end

        // Backpressure: word must stay put while a bit waits upstream
        c_word = 6'b101100;
        send_frame(c_word, 6, 1'b1, 1'b1, 0);
        check("bp_valid", 32'(bus.out_valid), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        bus.in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("bp_inrdy%0d", k), 32'(bus.in_ready), 32'd0);
            check($sformatf("bp_data%0d", k),  32'(bus.out_data), 32'(c_word));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("bp_rel_valid", 32'(bus.out_valid), 32'd0);
        check("bp_rel_inrdy", 32'(bus.in_ready),  32'd1);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        c_word = 6'b100000;
        check_word("bp_next", c_word, 1'b1, 1'b0, 0);

        // Reset in the middle of a frame
        for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b0, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_inrdy", 32'(bus.in_ready),  32'd1);
        c_word = 6'b010101;
        send_frame(c_word, 6, 1'b1, 1'b0, 0);
        check_word("mrst", c_word, 1'b0, PAR_EN ? 1'b1 : 1'b0, 0);

        // Randomized frames against a frame-level model
        for (int f = 0; f < 200; f++) begin
            len   = ($urandom_range(3, 0) == 0) ? int'($urandom_range(5, 1)) : 6;
            bits  = 6'($urandom);
            lastf = (len < 6) ? 1'b1 : 1'($urandom_range(1, 0));
            p     = 1'($urandom_range(1, 0));
            gap   = int'($urandom_range(2, 0));
            hold  = int'($urandom_range(3, 0));
            expd  = '0;
            ones  = 0;
            for (int i = 0; i < len; i++) begin
                expd[i] = bits[i];
                ones   += int'(bits[i]);
            end
            eerr  = (len < 6);
            eperr = (PAR_EN && len == 6) ? (((ones + int'(p)) % 2) == 1) : 1'b0;
            send_frame(bits, len, lastf, p, gap);
            check_word($sformatf("rnd%0d", f), expd, eerr, eperr, hold);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
